// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer,
// freeze/flush controls, bubble insertion and a flush-discard counter.
module pipe_skid_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] BUBBLE  = {WIDTH{1'b0}},
    parameter bit               SKID_EN = 1'b1,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push, pop;
    logic [1:0]         add;
    logic [CNT_W:0]     sum;

    assign occupancy = state_q;
    assign flush_cnt = cnt_q;

    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = out_valid ? main_q : BUBBLE;
        // rst gates in_ready so it reads 0 for the whole reset window
        if (SKID_EN)
            in_ready = (state_q != FULL) & ~freeze & rst;
        else
            in_ready = (~out_valid | out_ready) & ~freeze & rst;
        push    = in_valid & in_ready;
        pop     = out_valid & out_ready & ~freeze;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        add     = 2'd0;
        sum     = '0;
        if (!freeze) begin
            if (flush) begin
                state_d = EMPTY;
                main_d  = BUBBLE;
                skid_d  = BUBBLE;
                add     = occupancy - {1'b0, pop} + {1'b0, push};
                sum     = {1'b0, cnt_q} + (CNT_W+1)'(add);
                cnt_d   = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (push) begin
                            state_d = ONE;
                            main_d  = in_data;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            main_d = in_data;
                        end else if (push) begin
                            state_d = FULL;
                            skid_d  = in_data;
                        end else if (pop) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state_d = ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: skid instance and a single-entry,
// 2-bit-counter instance share stimulus; one is checked at a time.
module tb_pipe_skid_reg;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, flush, freeze, in_valid, out_ready;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;
    logic [1:0]  b_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          sel   = 0;
    int          m_cnt = 0;
    int          cnt_max = 65535;
    logic [31:0] q[$];
    bit          p;

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH(32), .BUBBLE(BUB), .SKID_EN(1'b1), .CNT_W(16)
    ) u_a (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ready(out_ready), .occupancy(a_occ), .flush_cnt(a_cnt)
    );

    pipe_skid_reg #(
        .WIDTH(32), .BUBBLE(BUB), .SKID_EN(1'b0), .CNT_W(2)
    ) u_b (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(out_ready), .occupancy(b_occ), .flush_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string pfx);
        logic [31:0] d, v, o, c;
        d = sel ? b_out_data : a_out_data;
        v = sel ? 32'(b_out_valid) : 32'(a_out_valid);
        o = sel ? 32'(b_occ) : 32'(a_occ);
        c = sel ? 32'(b_cnt) : 32'(a_cnt);
        chk({pfx, "out_valid"}, v, 32'(q.size() != 0));
        chk({pfx, "out_data"}, d, (q.size() != 0) ? q[0] : BUB);
        chk({pfx, "occupancy"}, o, 32'(q.size()));
        chk({pfx, "flush_cnt"}, c, 32'(m_cnt));
    endtask

    task automatic cyc(output bit pushed);
        bit exp_rdy, push, pop;
        int add;
        @(negedge clk);
        if (sel == 0)
            exp_rdy = (q.size() != 2) && !freeze;
        else
            exp_rdy = (q.size() == 0 || out_ready) && !freeze;
        chk("in_ready", sel ? 32'(b_in_ready) : 32'(a_in_ready),
            32'(exp_rdy));
        chk_outs("");
        push = in_valid && exp_rdy;
        pop  = (q.size() != 0) && out_ready && !freeze;
        @(posedge clk);
        if (!freeze) begin
            if (flush) begin
                add   = q.size() - int'(pop) + int'(push);
                m_cnt = (m_cnt + add > cnt_max) ? cnt_max : m_cnt + add;
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(in_data);
            end
        end
        pushed = push;
        #1;
    endtask

    // Asynchronous reset: checked before any clock edge can intervene.
    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        m_cnt = 0;
        #2;
        chk("rst_in_ready", sel ? 32'(b_in_ready) : 32'(a_in_ready), 32'd0);
        chk_outs("rst_");
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk);
        #1;
        do_reset();

        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            cyc(p);
        end
        in_valid = 1'b0;
        cyc(p); cyc(p);

        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b1;
        cyc(p);
        out_ready = 1'b0; in_data = 32'hB;
        cyc(p);
        in_data = 32'hC;
        cyc(p); cyc(p);
        out_ready = 1'b1;
        p = 1'b0;
        for (int k = 0; k < 10 && !p; k++) cyc(p);
        chk("c_accepted", 32'(p), 32'd1);
        in_valid = 1'b0;
        cyc(p); cyc(p); cyc(p);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1A1A;
        cyc(p);
        in_data = 32'h1B1B;
        cyc(p);
        in_valid = 1'b0; freeze = 1'b1; flush = 1'b1;
        cyc(p); cyc(p); cyc(p);
        freeze = 1'b0;
        cyc(p);
        flush = 1'b0;
        cyc(p);

        in_valid = 1'b1; in_data = 32'hC0DE;
        cyc(p);
        in_data = 32'hD00D; out_ready = 1'b1; flush = 1'b1;
        cyc(p);
        flush = 1'b0; in_valid = 1'b0;
        cyc(p);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        cyc(p);
        in_data = 32'h66;
        cyc(p);
        do_reset();
        in_valid = 1'b0;
        cyc(p);

        sel = 1; cnt_max = 3;
        do_reset();
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        cyc(p);
        in_valid = 1'b0;
        cyc(p);
        out_ready = 1'b1;
        cyc(p);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(k);
            cyc(p);
            in_valid = 1'b0; flush = 1'b1;
            cyc(p);
            flush = 1'b0;
        end
        cyc(p);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
